// File: rtl/multicycle_operand_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath. It drives the
// second-operand select and the IR/PC/RF/memory strobes, times out stalled memory handshakes and halts on faults.
module multicycle_operand_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic [2:0]  Si,
   output logic        ir_load,
   output logic        pc_load,
   output logic        rf_le,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        fault,
   output logic [31:0] retired
);

   localparam int unsigned WW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] SI_PB     = 3'b000;
   localparam logic [2:0] SI_IMM_I  = 3'b001;
   localparam logic [2:0] SI_IMM_S  = 3'b010;
   localparam logic [2:0] SI_IMM20  = 3'b011;
   localparam logic [2:0] SI_PC     = 3'b100;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   // Only the path through EXEC/MEM matters after decode, so four classes suffice.
   typedef enum logic [1:0] {
      CL_WB     = 2'd0,
      CL_BRANCH = 2'd1,
      CL_LOAD   = 2'd2,
      CL_STORE  = 2'd3
   } class_t;

   state_t          state_q, state_d;
   class_t          cls_q, cls_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [2:0]      si_q, si_d;
   logic [31:0]     retired_q, retired_d;

   logic            dec_legal;
   logic [2:0]      dec_si;
   class_t          dec_cls;
   logic            stall_timeout;
   logic            unused_instr;

   assign unused_instr  = ^instr[31:7];
   assign stall_timeout = (wait_q == WAIT_MAX);

   always_comb begin
      dec_legal = 1'b1;
      dec_si    = SI_PB;
      dec_cls   = CL_WB;
      case (instr[6:0])
         OP_R:      dec_si = SI_PB;
         OP_BRANCH: dec_cls = CL_BRANCH;
         OP_IALU:   dec_si = SI_IMM_I;
         OP_LOAD: begin
            dec_si  = SI_IMM_I;
            dec_cls = CL_LOAD;
         end
         OP_STORE: begin
            dec_si  = SI_IMM_S;
            dec_cls = CL_STORE;
         end
         OP_LUI, OP_AUIPC: dec_si = SI_IMM20;
         OP_JAL, OP_JALR:  dec_si = SI_PC;
         default:          dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         cls_q     <= CL_WB;
         wait_q    <= '0;
         si_q      <= SI_PB;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         wait_q    <= wait_d;
         si_q      <= si_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      wait_d    = wait_q;
      si_d      = si_q;
      retired_d = retired_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (stall_timeout) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_DECODE: begin
            if (dec_legal) begin
               state_d = S_EXEC;
               si_d    = dec_si;
               cls_d   = dec_cls;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_EXEC: begin
            case (cls_q)
               CL_LOAD, CL_STORE: state_d = S_MEM;
               CL_BRANCH: begin
                  state_d   = S_FETCH;
                  retired_d = retired_q + 32'd1;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (cls_q == CL_STORE) begin
                  state_d   = S_FETCH;
                  retired_d = retired_q + 32'd1;
               end else begin
                  state_d = S_WB;
               end
            end else if (stall_timeout) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         default: state_d = S_FAULT;
      endcase
      // Stall count is per-state: any transition restarts it.
      if (state_d != state_q) begin
         wait_d = '0;
      end
   end

   // Strobes are gated by reset so nothing fires while reset is held, even in FETCH.
   always_comb begin
      ir_load = 1'b0;
      pc_load = 1'b0;
      rf_le   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_rd  = 1'b1;
               ir_load = mem_ready;
            end
            S_EXEC: begin
               pc_load = (cls_q == CL_BRANCH) && br_taken;
            end
            S_MEM: begin
               mem_rd  = (cls_q == CL_LOAD);
               mem_wr  = (cls_q == CL_STORE);
               pc_load = (cls_q == CL_STORE) && mem_ready;
            end
            S_WB: begin
               rf_le   = 1'b1;
               pc_load = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fault   = (state_q == S_FAULT);
   assign Si      = si_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_operand_sequencer.sv
// Bench for multicycle_operand_sequencer: directed and randomized instruction streams
// compared cycle by cycle against a phase-list model of the instruction sequencing.
module tb_multicycle_operand_sequencer;

   localparam int LIMIT = 15;

   localparam logic [4:0] B_IR = 5'b10000;
   localparam logic [4:0] B_PC = 5'b01000;
   localparam logic [4:0] B_RF = 5'b00100;
   localparam logic [4:0] B_RD = 5'b00010;
   localparam logic [4:0] B_WR = 5'b00001;

   localparam int K_WB = 0;
   localparam int K_BR = 1;
   localparam int K_LD = 2;
   localparam int K_ST = 3;

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] SW   = 32'h00112023;
   localparam logic [31:0] LW   = 32'h0000A103;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] LUI  = 32'h123450B7;

   typedef struct {
      logic [31:0] ins;
      int          sf;
      int          sm;
      logic        br;
   } desc_t;

   typedef struct {
      logic [4:0] stb;
      logic       mr;
      logic       br;
   } cyc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        mem_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic [2:0]  Si;
   logic        ir_load, pc_load, rf_le, mem_rd, mem_wr, fault;
   logic [31:0] retired;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  si_exp = 3'b000;
   logic [31:0] ret_exp = 32'h0;
   cyc_t        cq[$];
   desc_t       dq[$];
   logic [6:0]  legal_ops [9] = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};

   always #5 clk = ~clk;

   multicycle_operand_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .instr     (instr),
      .mem_ready (mem_ready),
      .br_taken  (br_taken),
      .Si        (Si),
      .ir_load   (ir_load),
      .pc_load   (pc_load),
      .rf_le     (rf_le),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .fault     (fault),
      .retired   (retired)
   );

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [2:0] si_of(input logic [6:0] op);
      case (op)
         7'h33, 7'h63: return 3'b000;
         7'h13, 7'h03: return 3'b001;
         7'h23:        return 3'b010;
         7'h37, 7'h17: return 3'b011;
         default:      return 3'b100;
      endcase
   endfunction

   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'h63:   return K_BR;
         7'h03:   return K_LD;
         7'h23:   return K_ST;
         default: return K_WB;
      endcase
   endfunction

   function automatic desc_t mk(input logic [31:0] ins, input int sf, input int sm, input logic br);
      desc_t d;
      d.ins = ins; d.sf = sf; d.sm = sm; d.br = br;
      return d;
   endfunction

   // Expected per-cycle strobes for one instruction, built from its phase list.
   task automatic build_cycles(input desc_t d);
      int          k;
      logic [4:0]  mstb;
      k = kind_of(d.ins[6:0]);
      cq.delete();
      for (int i = 0; i < d.sf; i++) cq.push_back('{stb: B_RD, mr: 1'b0, br: rb()});
      cq.push_back('{stb: B_IR | B_RD, mr: 1'b1, br: rb()});
      cq.push_back('{stb: 5'b0, mr: rb(), br: rb()});
      if (k == K_BR) cq.push_back('{stb: d.br ? B_PC : 5'b0, mr: rb(), br: d.br});
      else           cq.push_back('{stb: 5'b0, mr: rb(), br: rb()});
      if (k == K_LD || k == K_ST) begin
         mstb = (k == K_LD) ? B_RD : B_WR;
         for (int i = 0; i < d.sm; i++) cq.push_back('{stb: mstb, mr: 1'b0, br: rb()});
         cq.push_back('{stb: (k == K_ST) ? (mstb | B_PC) : mstb, mr: 1'b1, br: rb()});
      end
      if (k == K_LD || k == K_WB) cq.push_back('{stb: B_RF | B_PC, mr: rb(), br: rb()});
   endtask

   task automatic do_reset();
      reset = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      si_exp = 3'b000; ret_exp = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; br_taken = 1'b1; instr = 32'h33;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, 5'b0);
      end
      checks++;
      if (Si !== 3'b000) begin errors++; $display("FAIL reset_si got=%b exp=000", Si); end
      checks++;
      if (retired !== 32'h0) begin errors++; $display("FAIL reset_retired got=%h exp=0", retired); end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
      @(posedge clk);
      #2 reset = 1'b0; mem_ready = 1'b0;
      #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== B_RD) begin
         errors++; $display("FAIL reset_release_fetch got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, B_RD);
      end
      $display("reset done");
   endtask

   task automatic test_back_to_back();
      desc_t      d;
      logic [2:0] si_new, si_want;
      int         dec_idx;
      for (int n = 0; n < dq.size(); n++) begin
         d = dq[n];
         build_cycles(d);
         si_new  = si_of(d.ins[6:0]);
         dec_idx = d.sf + 1;
         for (int i = 0; i < cq.size(); i++) begin
            @(negedge clk);
            instr = d.ins; mem_ready = cq[i].mr; br_taken = cq[i].br;
            #1;
            si_want = (i > dec_idx) ? si_new : si_exp;
            checks++;
            if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== cq[i].stb) begin
               errors++;
               $display("FAIL strobes instr=%h cyc=%0d got=%b exp=%b", d.ins, i, {ir_load, pc_load, rf_le, mem_rd, mem_wr}, cq[i].stb);
            end
            checks++;
            if (Si !== si_want) begin
               errors++; $display("FAIL si instr=%h cyc=%0d got=%b exp=%b", d.ins, i, Si, si_want);
            end
            checks++;
            if (retired !== ret_exp) begin
               errors++; $display("FAIL retired instr=%h cyc=%0d got=%0d exp=%0d", d.ins, i, retired, ret_exp);
            end
            checks++;
            if (fault !== 1'b0) begin
               errors++; $display("FAIL no_fault instr=%h cyc=%0d got=%b exp=0", d.ins, i, fault);
            end
         end
         ret_exp++;
         si_exp = si_new;
         $display("instr %0d %h sf=%0d sm=%0d br=%0d cycles=%0d", n, d.ins, d.sf, d.sm, d.br, cq.size());
      end
   endtask

   task automatic test_illegal();
      @(negedge clk); instr = 32'h0000007F; mem_ready = 1'b1; #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== (B_IR | B_RD)) begin
         errors++; $display("FAIL illegal_fetch got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, B_IR | B_RD);
      end
      @(negedge clk); mem_ready = rb(); #1;
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL illegal_decode_fault got=%b exp=0", fault); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ready = 1'b1; br_taken = rb(); #1;
         checks++;
         if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault cyc=%0d got=%b exp=1", i, fault); end
         checks++;
         if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== 5'b0) begin
            errors++; $display("FAIL illegal_strobes cyc=%0d got=%b exp=0", i, {ir_load, pc_load, rf_le, mem_rd, mem_wr});
         end
         checks++;
         if (Si !== si_exp) begin errors++; $display("FAIL illegal_si_held cyc=%0d got=%b exp=%b", i, Si, si_exp); end
         checks++;
         if (retired !== ret_exp) begin errors++; $display("FAIL illegal_retired cyc=%0d got=%0d exp=%0d", i, retired, ret_exp); end
      end
      $display("illegal opcode done");
      do_reset();
   endtask

   task automatic test_reset_mid_mem();
      instr = ADDI;
      for (int i = 0; i < 4; i++) begin @(negedge clk); mem_ready = 1'b1; end
      instr = LW;
      for (int i = 0; i < 3; i++) begin @(negedge clk); mem_ready = 1'b1; end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== B_RD) begin
         errors++; $display("FAIL midmem_before got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, B_RD);
      end
      checks++;
      if (retired !== 32'd1 || Si !== 3'b001) begin
         errors++; $display("FAIL midmem_state got=%0d/%b exp=1/001", retired, Si);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== 5'b0) begin
         errors++; $display("FAIL midmem_strobes got=%b exp=0", {ir_load, pc_load, rf_le, mem_rd, mem_wr});
      end
      checks++;
      if (Si !== 3'b000 || retired !== 32'h0 || fault !== 1'b0) begin
         errors++; $display("FAIL midmem_regs got=%b/%0d/%b exp=000/0/0", Si, retired, fault);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== B_RD) begin
         errors++; $display("FAIL midmem_restart got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, B_RD);
      end
      si_exp = 3'b000; ret_exp = 32'h0;
      $display("reset mid-MEM done");
   endtask

   task automatic test_fetch_timeout();
      for (int i = 0; i <= LIMIT; i++) begin
         @(negedge clk); mem_ready = 1'b0; #1;
         checks++;
         if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== B_RD || fault !== 1'b0) begin
            errors++; $display("FAIL fetch_stall cyc=%0d got=%b/%b exp=%b/0", i, {ir_load, pc_load, rf_le, mem_rd, mem_wr}, fault, B_RD);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ready = (i != 0); #1;
         checks++;
         if (fault !== 1'b1 || {ir_load, pc_load, rf_le, mem_rd, mem_wr} !== 5'b0) begin
            errors++; $display("FAIL fetch_timeout cyc=%0d got=%b/%b exp=1/00000", i, fault, {ir_load, pc_load, rf_le, mem_rd, mem_wr});
         end
      end
      $display("fetch timeout done");
      do_reset();
   endtask

   task automatic test_mem_timeout();
      instr = SW;
      for (int i = 0; i < 3; i++) begin @(negedge clk); mem_ready = 1'b1; end
      for (int i = 0; i <= LIMIT; i++) begin
         @(negedge clk); mem_ready = 1'b0; #1;
         checks++;
         if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== B_WR || fault !== 1'b0) begin
            errors++; $display("FAIL mem_stall cyc=%0d got=%b/%b exp=%b/0", i, {ir_load, pc_load, rf_le, mem_rd, mem_wr}, fault, B_WR);
         end
      end
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (fault !== 1'b1 || {ir_load, pc_load, rf_le, mem_rd, mem_wr} !== 5'b0 || retired !== 32'h0) begin
         errors++; $display("FAIL mem_timeout got=%b/%b/%0d exp=1/00000/0", fault, {ir_load, pc_load, rf_le, mem_rd, mem_wr}, retired);
      end
      $display("mem timeout done");
      do_reset();
   endtask

   task automatic test_wrap();
      @(negedge clk);
      dut.retired_q = 32'hFFFF_FFFF;
      instr = ADDI; mem_ready = 1'b1;
      #1;
      checks++;
      if (retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset got=%h exp=ffffffff", retired); end
      for (int i = 1; i < 4; i++) begin @(negedge clk); mem_ready = 1'b1; end
      #1;
      checks++;
      if ({ir_load, pc_load, rf_le, mem_rd, mem_wr} !== (B_RF | B_PC)) begin
         errors++; $display("FAIL wrap_wb got=%b exp=%b", {ir_load, pc_load, rf_le, mem_rd, mem_wr}, B_RF | B_PC);
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++;
      if (retired !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", retired); end
      checks++;
      if (Si !== 3'b001) begin errors++; $display("FAIL wrap_si got=%b exp=001", Si); end
      $display("retired wrap done");
   endtask

   initial begin
      logic [31:0] r;
      dq.push_back(mk(ADDI, 0, 0, 1'b0));
      dq.push_back(mk(SW, 0, 0, 1'b0));
      dq.push_back(mk(LW, 0, 3, 1'b0));
      dq.push_back(mk(BEQ, 0, 0, 1'b1));
      dq.push_back(mk(BEQ, 0, 0, 1'b0));
      dq.push_back(mk(ADDI, LIMIT, 0, 1'b0));
      dq.push_back(mk(SW, 0, LIMIT, 1'b0));
      for (int n = 0; n < 40; n++) begin
         r = $urandom();
         r[6:0] = legal_ops[$urandom_range(0, 8)];
         dq.push_back(mk(r, $urandom_range(0, 3), $urandom_range(0, 3), rb()));
      end
      dq.push_back(mk(LUI, 1, 0, 1'b0));

      test_reset();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mem();
      test_fetch_timeout();
      test_mem_timeout();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
